regfile_sb: RTL

Parametrised integer register file with hardwired-zero x0, same-cycle write-to-read bypass, and a per-register pending-write scoreboard for the pipelined NPC core. Decode reads operands and asks whether each is still awaiting writeback. Issue reserves the destination register. Writeback commits data and releases one reservation. Sits between ID (read/issue side) and WB (write side).

---
 rtl/regfile_sb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with hardwired-zero x0, same-cycle write-to-read
// bypass and a per-register pending-write scoreboard sitting between ID and WB.
// Latency: reads and rbusy/issue_ready are combinational; writes and counters take 1 edge.
// Backpressure: io_issue_ready drops when the destination's pending counter is saturated.
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   io_raddr/io_rdata     - NR_READ packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   io_rbusy              - per read port: operand still awaiting writeback
//   io_issue_valid/_rd    - reserve a destination register; io_issue_ready accepts it
//   io_wen/io_waddr/io_wdata - writeback: commit data and release one reservation
//   io_flush              - clear every reservation on the next edge (data write still happens)
//   io_pending_any        - registered: some counter is nonzero
// Optional macro RF_TRACE_EN: prints writes and protocol warnings in simulation.

module regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32,
  parameter int NR_READ = 2,
  parameter int PEND_W  = 2,
  localparam int AW     = $clog2(NR_REGS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NR_READ*AW-1:0]   io_raddr,
  output logic [NR_READ*XLEN-1:0] io_rdata,
  output logic [NR_READ-1:0]      io_rbusy,
  input  logic                    io_issue_valid,
  input  logic [AW-1:0]           io_issue_rd,
  output logic                    io_issue_ready,
  input  logic                    io_wen,
  input  logic [AW-1:0]           io_waddr,
  input  logic [XLEN-1:0]         io_wdata,
  input  logic                    io_flush,
  output logic                    io_pending_any
);

  // x0 has no storage and no counter; arrays start at index 1.
  logic [XLEN-1:0]   rf_q  [NR_REGS-1:1];
  logic [XLEN-1:0]   rf_d  [NR_REGS-1:1];
  logic [PEND_W-1:0] cnt_q [NR_REGS-1:1];
  logic [PEND_W-1:0] cnt_d [NR_REGS-1:1];

  logic [PEND_W-1:0] issue_cnt;
  logic              issue_fire;

  // Issue readiness looks only at the current counters; a same-cycle retire is not credited.
  always_comb begin
    issue_cnt = '0;
    for (int r = 1; r < NR_REGS; r++) begin
      if (io_issue_rd == AW'(r)) issue_cnt = cnt_q[r];
    end
    io_issue_ready = (io_issue_rd == '0) || (issue_cnt != '1);
    issue_fire     = io_issue_valid && io_issue_ready && (io_issue_rd != '0);
  end

  // Next-state for data and counters. Address compares run over r >= 1 only, so a
  // write or issue to x0 never matches anything.
  always_comb begin
    logic iss;
    logic ret;
    for (int r = 1; r < NR_REGS; r++) begin
      rf_d[r]  = rf_q[r];
      cnt_d[r] = cnt_q[r];
      iss = issue_fire && (io_issue_rd == AW'(r));
      ret = io_wen && (io_waddr == AW'(r));
      if (ret) rf_d[r] = io_wdata;
      if (io_flush) begin
        cnt_d[r] = '0;
      end else if (iss && !ret) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (ret && !iss && (cnt_q[r] != '0)) begin
        // A stray write to an idle register leaves the counter at 0.
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NR_REGS; r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NR_REGS; r++) begin
        rf_q[r]  <= rf_d[r];
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Read ports. The busy exception covers the final outstanding write whose data is
  // being bypassed this very cycle.
  always_comb begin
    logic [AW-1:0]     ra;
    logic [XLEN-1:0]   rval;
    logic [PEND_W-1:0] rcnt;
    io_rdata = '0;
    io_rbusy = '0;
    for (int i = 0; i < NR_READ; i++) begin
      ra   = io_raddr[i*AW +: AW];
      rval = '0;
      rcnt = '0;
      for (int r = 1; r < NR_REGS; r++) begin
        if (ra == AW'(r)) begin
          rval = rf_q[r];
          rcnt = cnt_q[r];
        end
      end
      if ((ra != '0) && io_wen && (io_waddr == ra)) rval = io_wdata;
      io_rdata[i*XLEN +: XLEN] = rval;
      io_rbusy[i] = (rcnt != '0) &&
                    !(io_wen && (io_waddr == ra) && (rcnt == PEND_W'(1)));
    end
  end

  always_comb begin
    io_pending_any = 1'b0;
    for (int r = 1; r < NR_REGS; r++) begin
      if (cnt_q[r] != '0) io_pending_any = 1'b1;
    end
  end

`ifdef RF_TRACE_EN
  always @(posedge clock) begin
    logic [PEND_W-1:0] wcnt;
    wcnt = '0;
    for (int r = 1; r < NR_REGS; r++) begin
      if (io_waddr == AW'(r)) wcnt = cnt_q[r];
    end
    if (!reset) begin
      if (io_wen && (io_waddr != '0))
        $display("waddr = %h, wdata = %h", io_waddr, io_wdata);
      if (io_issue_valid && !io_issue_ready)
        $display("regfile_sb warning: issue to x%0d while not ready", io_issue_rd);
      if (io_wen && (io_waddr != '0) && (wcnt == '0))
        $display("regfile_sb warning: write to x%0d with no pending reservation", io_waddr);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule
